// File: rtl/dmem_ctrl.sv
// Data-memory controller that sits behind the EX/MEM stage.
// It holds a word RAM with byte-lane strobes and a small MMIO window.
// The MMIO window contains a console byte FIFO and a 64-bit cycle counter.
// Read data is registered, so it is valid one cycle after the address.
module dmem_ctrl #(
  parameter int unsigned RAM_WORDS  = 4096,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] MMIO_BASE  = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wrdata,
  input  logic [3:0]  dmem_wrstb,
  output logic [31:0] dmem_rddata,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned FW = $clog2(FIFO_DEPTH);
  // One bit wider than the address so a RAM that fills the whole space cannot overflow.
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

  typedef enum logic [5:0] {
    REG_CON_DATA   = 6'h00,
    REG_CON_STATUS = 6'h01,
    REG_CYCLE_LO   = 6'h02,
    REG_CYCLE_HI   = 6'h03
  } mmio_reg_e;

  // Storage
  logic [31:0]   r_ram  [RAM_WORDS];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [FW-1:0] r_rd_ptr;
  logic [FW-1:0] r_wr_ptr;
  logic [FW:0]   r_count;
  logic [63:0]   r_cycle;
  logic [31:0]   r_rddata;

  // Decode and control
  logic          w_is_ram;
  logic          w_is_mmio;
  logic [AW-1:0] w_ram_idx;
  logic [5:0]    w_reg_sel;
  logic          w_full;
  logic          w_empty;
  logic          w_con_wr;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_status;
  logic [31:0]   w_rd_data;

  // RAM wins if a parameter choice ever makes it overlap the MMIO window.
  assign w_is_ram  = {1'b0, dmem_addr} < RAM_BYTES;
  assign w_is_mmio = !w_is_ram && (dmem_addr[31:8] == MMIO_BASE[31:8]);
  assign w_ram_idx = dmem_addr[AW+1:2];
  assign w_reg_sel = dmem_addr[7:2];

  assign w_full    = (r_count == (FW+1)'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_con_wr  = w_is_mmio && (w_reg_sel == REG_CON_DATA) && dmem_wrstb[0];
  assign w_pop     = con_valid && con_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_push    = w_con_wr && (!w_full || w_pop);

  assign con_valid   = !w_empty;
  // Forced to zero when empty so stale storage never shows on the port.
  assign con_data    = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
  assign dmem_rddata = r_rddata;

  // Assemble the console status word from the pre-edge FIFO state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_status          = '0;
    w_status[FW+8:8]  = r_count;
    w_status[1]       = w_empty;
    w_status[0]       = w_full;
  end

  // Select read data for the current address; unmapped space reads zero.
  always_comb begin
    w_rd_data = '0;
    if (w_is_ram) begin
      w_rd_data = r_ram[w_ram_idx];
    end else if (w_is_mmio) begin
      case (w_reg_sel)
        REG_CON_STATUS: w_rd_data = w_status;
        REG_CYCLE_LO:   w_rd_data = r_cycle[31:0];
        REG_CYCLE_HI:   w_rd_data = r_cycle[63:32];
        default:        w_rd_data = '0;
      endcase
    end
  end

  // Byte-lane RAM writes; the registered read below sees the old word (read-first).
  always_ff @(posedge clk) begin
    // NOTE: RAM contents are deliberately not reset; reset only blocks writes for that cycle.
    if (rst_n && w_is_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (dmem_wrstb[b]) begin
          r_ram[w_ram_idx][8*b +: 8] <= dmem_wrdata[8*b +: 8];
        end
      end
    end
  end

  // Register read data to give exactly one cycle of latency.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_rddata <= '0;
    end else begin
      r_rddata <= w_rd_data;
    end
  end

  // Free-running cycle counter; wraps naturally at 2^64.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
    end
  end

  // Console FIFO storage; the write slot is only used when a push is accepted.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_fifo[r_wr_ptr] <= dmem_wrdata[7:0];
    end
  end

  // Console FIFO pointers and occupancy; pointers wrap modulo the depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FW+1)'(1);
        2'b01:   r_count <= r_count - (FW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the CPU's EX/MEM DMEM interface; it consumes dmem_addr/dmem_wrdata/dmem_wrstb and produces dmem_rddata for the WB stage.
- Contains on-chip word RAM with byte-lane write strobes, plus a small MMIO window.
- MMIO window holds a console output FIFO, drained by an external valid/ready sink, and a free-running 64-bit cycle counter.
- Read data is registered, giving exactly one cycle of latency to match the MEM->WB timing.

Parameters:
- RAM_WORDS, 4096, number of 32-bit RAM words; power of 2, >= 2.
- FIFO_DEPTH, 16, console FIFO entries; power of 2, >= 2.
- MMIO_BASE, 32'hF000_0000, MMIO window base; bits [7:0] must be zero.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- dmem_addr  input  32  byte address from EX/MEM
- dmem_wrdata  input  32  store data from EX/MEM
- dmem_wrstb  input  4  byte-lane write strobes; bit i enables bits [8i+7:8i]; 0 = no write
- dmem_rddata  output  32  registered read data, valid in the cycle after the address
- con_data  output  8  head byte of console FIFO
- con_valid  output  1  FIFO non-empty
- con_ready  input  1  sink accepts con_data this cycle

Behaviour:
- Reset is synchronous on the clk edge with rst_n=0, and overrides all else.
  - dmem_rddata=0; FIFO empty (con_valid=0, con_data=0); cycle counter=0.
  - RAM contents are not reset.
- Address decode uses dmem_addr; addr[1:0] is ignored (word access; lanes are selected by wrstb only).
  - RAM: addr < RAM_WORDS*4; index = addr[log2(RAM_WORDS)+1:2].
  - MMIO: addr[31:8] == MMIO_BASE[31:8]; register select = addr[7:2].
  - Anything else is unmapped: reads return 0, writes are ignored.
- Read path: every cycle, dmem_rddata <= data(dmem_addr) at the posedge. No read enable exists; reads have no side effects.
- Write path: a RAM write with wrstb != 0 updates only the enabled lanes at the posedge.
- Same-address read and write in one cycle is read-first: dmem_rddata gets the old word.
- MMIO map (offsets from MMIO_BASE):
  - 0x00 CON_DATA. Write with wrstb[0]=1 pushes wrdata[7:0]. Read returns 0.
  - 0x04 CON_STATUS, read-only:
    - bit0 = full, bit1 = empty.
    - bits[log2(FIFO_DEPTH)+8:8] = occupancy count (0..FIFO_DEPTH).
    - all other bits 0.
  - 0x08 CYCLE_LO, read-only: counter[31:0].
  - 0x0C CYCLE_HI, read-only: counter[63:32].
  - Other offsets: read 0, writes ignored.
  - Writes to read-only registers are ignored.
- Cycle counter: increments by 1 every non-reset cycle and wraps 2^64-1 -> 0. A read returns the pre-edge value.
- Console FIFO is a circular buffer with read/write pointers and a count.
  - pop = con_valid & con_ready.
  - push = CON_DATA write & (!full | pop).
  - Push when full with no pop: the byte is dropped silently; state is unchanged.
  - Full with simultaneous pop and push: both occur; count stays FIFO_DEPTH; order is preserved.
  - Empty with push: con_valid rises the next cycle. There is no same-cycle bypass.
  - con_data = mem[rd_ptr], stable while con_valid=1 and con_ready=0.
  - Pointers wrap modulo FIFO_DEPTH.
- Status reads reflect pre-edge full/empty/count, before any same-cycle push/pop.
- Reset mid-operation discards FIFO contents immediately. con_valid=0 in the cycle after the reset edge, regardless of con_ready.

Test Plan:
- Reset, then read 0x0 in cycle N -> dmem_rddata=0 before cycle N+1; cycle counter read via 0xF000_0008 returns a small value that increases by the gap between reads.
- Write 0x11223344 to 0x10 with wrstb=4'b1111, then wrstb=4'b0010 with data 0xAABBCCDD -> read 0x10 returns 0x1122CC44 one cycle after the address.
- Write 0xDEADBEEF to 0x20 and read 0x20 in the same cycle -> old value returned; the next cycle returns 0xDEADBEEF.
- With con_ready=0, push 17 bytes 0x00..0x10 -> CON_STATUS=0x0000_1001 (count 16, full); byte 0x10 dropped. Raise con_ready -> sink receives 0x00..0x0F in order, then con_valid=0 and STATUS=0x0000_0002.
- Fill FIFO, then hold con_ready=1 and push 0x55 in the same cycle -> count stays 16; 0x55 emerges after the 16 original bytes.
- Read 0x4000_0000 (unmapped) -> 0. Preload counter near 2^32-1 via a long run or force -> CYCLE_HI increments exactly when CYCLE_LO wraps to 0. Assert rst_n=0 with FIFO holding 5 bytes -> con_valid=0 next cycle and STATUS empty.
